// File: rtl/calc_pkg.sv
// Shared types and constants for the four-port calculator core.
// All vectors are big-endian: bit 0 is the MSB.
package calc_pkg;

    typedef logic [0:3]  cmd_t;
    typedef logic [0:1]  tag_t;
    typedef logic [0:1]  resp_t;
    typedef logic [0:31] data_t;

    localparam cmd_t CMD_IDLE = 4'b0000;
    localparam cmd_t CMD_ADD  = 4'b0001;
    localparam cmd_t CMD_SUB  = 4'b0010;
    localparam cmd_t CMD_SHL  = 4'b0101;
    localparam cmd_t CMD_SHR  = 4'b0110;

    localparam resp_t RESP_NONE = 2'b00;
    localparam resp_t RESP_OK   = 2'b01;
    localparam resp_t RESP_ERR  = 2'b10;

    // A port is either waiting for a command or collecting its second operand.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OPND2 = 1'b1
    } port_state_e;

endpackage

// File: rtl/calc_port_unit.sv
// One calculator port: two-cycle command capture, ALU and a one-cycle
// registered response. A command seen in cycle T answers in cycle T+3.
module calc_port_unit
    import calc_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  cmd_t  cmd_i,
    input  tag_t  tag_i,
    input  data_t data_i,
    output data_t data_o,
    output resp_t resp_o,
    output tag_t  tag_o
);

    port_state_e state_q, state_d;
    cmd_t        cmd_q;
    tag_t        tag_q;
    data_t       op1_q;
    data_t       op2_q;
    logic        go_q;
    data_t       resultData_q;
    resp_t       resultResp_q;
    tag_t        resultTag_q;

    logic        loadOp1;
    logic        loadOp2;
    data_t       aluData;
    resp_t       aluResp;
    logic [0:32] sum;

    // State register; reset abandons any half-collected command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and operand load strobes; cmd is ignored in the op2 cycle.
    always_comb begin
        state_d = state_q;
        loadOp1 = 1'b0;
        loadOp2 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_i != CMD_IDLE) begin
                    loadOp1 = 1'b1;
                    state_d = ST_OPND2;
                end
            end
            ST_OPND2: begin
                loadOp2 = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture; go_q marks the cycle in which the ALU result is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q <= CMD_IDLE;
            tag_q <= '0;
            op1_q <= '0;
            op2_q <= '0;
            go_q  <= 1'b0;
        end else begin
            if (loadOp1) begin
                cmd_q <= cmd_i;
                tag_q <= tag_i;
                op1_q <= data_i;
            end
            if (loadOp2) begin
                op2_q <= data_i;
            end
            go_q <= loadOp2;
        end
    end

    // Unsigned 32-bit ALU; overflow, underflow and unknown opcodes give ERR with zero data.
    always_comb begin
        sum     = '0;
        aluData = '0;
        aluResp = RESP_ERR;
        case (cmd_q)
            CMD_ADD: begin
                sum = {1'b0, op1_q} + {1'b0, op2_q};
                if (!sum[0]) begin
                    aluData = sum[1:32];
                    aluResp = RESP_OK;
                end
            end
            CMD_SUB: begin
                if (op2_q <= op1_q) begin
                    aluData = op1_q - op2_q;
                    aluResp = RESP_OK;
                end
            end
            CMD_SHL: begin
                aluData = op1_q << op2_q[27:31];
                aluResp = RESP_OK;
            end
            CMD_SHR: begin
                aluData = op1_q >> op2_q[27:31];
                aluResp = RESP_OK;
            end
            default: begin
                aluData = '0;
                aluResp = RESP_ERR;
            end
        endcase
    end

    // Response register holds a result for exactly one cycle, otherwise all zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resultData_q <= '0;
            resultResp_q <= RESP_NONE;
            resultTag_q  <= '0;
        end else if (go_q) begin
            resultData_q <= aluData;
            resultResp_q <= aluResp;
            resultTag_q  <= tag_q;
        end else begin
            resultData_q <= '0;
            resultResp_q <= RESP_NONE;
            resultTag_q  <= '0;
        end
    end

    assign data_o = resultData_q;
    assign resp_o = resultResp_q;
    assign tag_o  = resultTag_q;

endmodule

// File: rtl/calc4_port_core.sv
// Four independent calculator ports sharing one clock and reset.
// Scan hooks are accepted but have no function; scan_out is held low.
module calc4_port_core
    import calc_pkg::*;
(
    input  logic  main_clk,
    input  logic  reset,
    input  cmd_t  req1_cmd_in,
    input  tag_t  req1_tag_in,
    input  data_t req1_data_in,
    input  cmd_t  req2_cmd_in,
    input  tag_t  req2_tag_in,
    input  data_t req2_data_in,
    input  cmd_t  req3_cmd_in,
    input  tag_t  req3_tag_in,
    input  data_t req3_data_in,
    input  cmd_t  req4_cmd_in,
    input  tag_t  req4_tag_in,
    input  data_t req4_data_in,
    output data_t out_data1,
    output resp_t out_resp1,
    output tag_t  out_tag1,
    output data_t out_data2,
    output resp_t out_resp2,
    output tag_t  out_tag2,
    output data_t out_data3,
    output resp_t out_resp3,
    output tag_t  out_tag3,
    output data_t out_data4,
    output resp_t out_resp4,
    output tag_t  out_tag4,
    input  logic  scan_in,
    input  logic  a_clk,
    input  logic  b_clk,
    output logic  scan_out
);

    logic unused_scan;
    assign unused_scan = scan_in ^ a_clk ^ b_clk;
    assign scan_out    = 1'b0;

    calc_port_unit u_port1 (
        .clk(main_clk), .rst_n(reset),
        .cmd_i(req1_cmd_in), .tag_i(req1_tag_in), .data_i(req1_data_in),
        .data_o(out_data1), .resp_o(out_resp1), .tag_o(out_tag1)
    );

    calc_port_unit u_port2 (
        .clk(main_clk), .rst_n(reset),
        .cmd_i(req2_cmd_in), .tag_i(req2_tag_in), .data_i(req2_data_in),
        .data_o(out_data2), .resp_o(out_resp2), .tag_o(out_tag2)
    );

    calc_port_unit u_port3 (
        .clk(main_clk), .rst_n(reset),
        .cmd_i(req3_cmd_in), .tag_i(req3_tag_in), .data_i(req3_data_in),
        .data_o(out_data3), .resp_o(out_resp3), .tag_o(out_tag3)
    );

    calc_port_unit u_port4 (
        .clk(main_clk), .rst_n(reset),
        .cmd_i(req4_cmd_in), .tag_i(req4_tag_in), .data_i(req4_data_in),
        .data_o(out_data4), .resp_o(out_resp4), .tag_o(out_tag4)
    );

endmodule

// File: tb/tb_calc4_port_core.sv
// Randomized and directed bench for calc4_port_core with a per-cycle
// expected-response table filled from plain unsigned arithmetic.
module tb_calc4_port_core;
    import calc_pkg::*;

    localparam int MAXC = 1000;

    typedef struct {
        bit [3:0]  cmd;
        bit [1:0]  tag;
        bit [31:0] op1;
        bit [31:0] op2;
    } req_s;

    logic  main_clk = 1'b0;
    logic  reset    = 1'b0;
    logic  scan_in  = 1'b0;
    logic  a_clk    = 1'b0;
    logic  b_clk    = 1'b0;
    logic  scan_out;

    cmd_t  reqCmd  [4];
    tag_t  reqTag  [4];
    data_t reqData [4];
    data_t outData [4];
    resp_t outResp [4];
    tag_t  outTag  [4];

    bit [31:0] expData [4][MAXC];
    bit [1:0]  expResp [4][MAXC];
    bit [1:0]  expTag  [4][MAXC];

    bit   pend [4];
    req_s cur  [4];
    req_s fq   [4][$];

    int cyc     = 0;
    bit rstReq  = 1'b1;
    bit randEn  = 1'b0;
    int nChecks = 0;
    int nFails  = 0;

    calc4_port_core dut (
        .main_clk(main_clk), .reset(reset),
        .req1_cmd_in(reqCmd[0]), .req1_tag_in(reqTag[0]), .req1_data_in(reqData[0]),
        .req2_cmd_in(reqCmd[1]), .req2_tag_in(reqTag[1]), .req2_data_in(reqData[1]),
        .req3_cmd_in(reqCmd[2]), .req3_tag_in(reqTag[2]), .req3_data_in(reqData[2]),
        .req4_cmd_in(reqCmd[3]), .req4_tag_in(reqTag[3]), .req4_data_in(reqData[3]),
        .out_data1(outData[0]), .out_resp1(outResp[0]), .out_tag1(outTag[0]),
        .out_data2(outData[1]), .out_resp2(outResp[1]), .out_tag2(outTag[1]),
        .out_data3(outData[2]), .out_resp3(outResp[2]), .out_tag3(outTag[2]),
        .out_data4(outData[3]), .out_resp4(outResp[3]), .out_tag4(outTag[3]),
        .scan_in(scan_in), .a_clk(a_clk), .b_clk(b_clk), .scan_out(scan_out)
    );

    // Free-running system clock.
    always #5 main_clk = ~main_clk;

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", name, cyc, observed, expected);
        end
    endtask

    // Reference result straight from the arithmetic rules.
    function automatic void refCalc(input req_s r, output bit [31:0] d, output bit [1:0] rs);
        longint unsigned a  = longint'(r.op1);
        longint unsigned b  = longint'(r.op2);
        int              sh = int'(r.op2 % 32);
        d  = 32'h0;
        rs = 2'b10;
        case (r.cmd)
            4'd1: if (a + b <= 64'hFFFF_FFFF) begin d = 32'(a + b); rs = 2'b01; end
            4'd2: if (b <= a) begin d = 32'(a - b); rs = 2'b01; end
            4'd5: begin d = 32'(a << sh); rs = 2'b01; end
            4'd6: begin d = 32'(a >> sh); rs = 2'b01; end
            default: begin d = 32'h0; rs = 2'b10; end
        endcase
    endfunction

    function automatic req_s randReq();
        req_s r;
        int   k = int'($urandom_range(0, 9));
        if (k < 3)      r.cmd = 4'd1;
        else if (k < 5) r.cmd = 4'd2;
        else if (k < 7) r.cmd = 4'd5;
        else if (k < 9) r.cmd = 4'd6;
        else            r.cmd = 4'($urandom_range(1, 15));
        r.tag = 2'($urandom);
        r.op1 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
        r.op2 = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
        return r;
    endfunction

    task automatic checkPort(input int p);
        checkOutput($sformatf("port%0d data", p + 1), outData[p], expData[p][cyc]);
        checkOutput($sformatf("port%0d resp", p + 1), 32'(outResp[p]), 32'(expResp[p][cyc]));
        checkOutput($sformatf("port%0d tag", p + 1), 32'(outTag[p]), 32'(expTag[p][cyc]));
    endtask

    task automatic drivePort(input int p);
        bit [31:0] d;
        bit [1:0]  rs;
        if (pend[p]) begin
            reqCmd[p]  = 4'($urandom_range(1, 15));
            reqTag[p]  = 2'($urandom);
            reqData[p] = cur[p].op2;
            refCalc(cur[p], d, rs);
            if (cyc + 2 < MAXC) begin
                expData[p][cyc + 2] = d;
                expResp[p][cyc + 2] = rs;
                expTag[p][cyc + 2]  = cur[p].tag;
            end
            pend[p] = 1'b0;
        end else if (!rstReq && fq[p].size() > 0) begin
            cur[p]     = fq[p].pop_front();
            reqCmd[p]  = cur[p].cmd;
            reqTag[p]  = cur[p].tag;
            reqData[p] = cur[p].op1;
            pend[p]    = 1'b1;
        end else if (!rstReq && randEn && $urandom_range(0, 9) < 6) begin
            cur[p]     = randReq();
            reqCmd[p]  = cur[p].cmd;
            reqTag[p]  = cur[p].tag;
            reqData[p] = cur[p].op1;
            pend[p]    = 1'b1;
        end else begin
            reqCmd[p]  = rstReq ? 4'($urandom_range(0, 15)) : 4'd0;
            reqTag[p]  = 2'($urandom);
            reqData[p] = $urandom;
        end
    endtask

    // One clock cycle: check outputs, apply/hold reset, drive next inputs.
    task automatic applyStimulus();
        @(negedge main_clk);
        for (int p = 0; p < 4; p++) checkPort(p);
        checkOutput("scan_out", 32'(scan_out), 32'h0);
        if (rstReq) begin
            reset = 1'b0;
            for (int p = 0; p < 4; p++) begin
                pend[p] = 1'b0;
                for (int k = cyc; k < MAXC; k++) begin
                    expData[p][k] = 32'h0;
                    expResp[p][k] = 2'b00;
                    expTag[p][k]  = 2'b00;
                end
            end
            #1;
            for (int p = 0; p < 4; p++) checkPort(p);
        end else begin
            reset = 1'b1;
        end
        for (int p = 0; p < 4; p++) drivePort(p);
        cyc++;
    endtask

    initial begin
        for (int p = 0; p < 4; p++) begin
            reqCmd[p]  = 4'd0;
            reqTag[p]  = 2'd0;
            reqData[p] = 32'h0;
            pend[p]    = 1'b0;
        end
        $display("[TB] starting calc4_port_core bench");

        rstReq = 1'b1;
        repeat (3) applyStimulus();
        rstReq = 1'b0;

        fq[0].push_back('{4'd1, 2'd2, 32'h0000_0005, 32'h0000_0007});
        repeat (6) applyStimulus();

        fq[0].push_back('{4'd1, 2'd1, 32'hFFFF_FFFF, 32'h0000_0001});
        fq[0].push_back('{4'd2, 2'd2, 32'h0000_0003, 32'h0000_0005});
        fq[0].push_back('{4'd2, 2'd3, 32'h0000_0005, 32'h0000_0005});
        fq[0].push_back('{4'd5, 2'd0, 32'h0000_0001, 32'h0000_001F});
        fq[0].push_back('{4'd6, 2'd1, 32'h8000_0000, 32'h0000_0021});
        fq[2].push_back('{4'd3, 2'd1, 32'h1234_5678, 32'h0000_0009});
        repeat (14) applyStimulus();

        fq[0].push_back('{4'd1, 2'd0, 32'h0000_0010, 32'h0000_0001});
        fq[1].push_back('{4'd1, 2'd1, 32'h7FFF_FFFF, 32'h0000_0001});
        fq[2].push_back('{4'd1, 2'd2, 32'hFFFF_FFFE, 32'h0000_0001});
        fq[3].push_back('{4'd1, 2'd3, 32'h0001_0000, 32'h0002_0000});
        repeat (6) applyStimulus();

        fq[1].push_back('{4'd2, 2'd0, 32'h0000_0100, 32'h0000_0001});
        fq[1].push_back('{4'd5, 2'd3, 32'h0000_00F0, 32'h0000_0004});
        repeat (8) applyStimulus();

        fq[1].push_back('{4'd1, 2'd3, 32'h0000_0011, 32'h0000_0022});
        applyStimulus();
        applyStimulus();
        fq[0].push_back('{4'd1, 2'd2, 32'h0000_0040, 32'h0000_0002});
        applyStimulus();
        rstReq = 1'b1;
        repeat (2) applyStimulus();
        rstReq = 1'b0;
        fq[0].push_back('{4'd1, 2'd1, 32'h0000_0001, 32'h0000_0001});
        repeat (6) applyStimulus();

        randEn = 1'b1;
        repeat (300) applyStimulus();
        rstReq = 1'b1;
        repeat (2) applyStimulus();
        rstReq = 1'b0;
        repeat (300) applyStimulus();
        randEn = 1'b0;
        repeat (6) applyStimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/calc4_port_core.md
# calc4_port_core

Four-port, 32-bit integer calculator core. Each of four independent request ports accepts a two-cycle command (opcode/tag/operand 1, then operand 2). Each port returns a tagged response on its own result port after a fixed latency. The block drives the calc2 port-level environment: the stimulus bundle supplies commands, the checker bundle receives results, and the global bundle carries the clock and reset.

## Interface
- No parameters. Widths are fixed: data 32, cmd 4, tag 2, resp 2. All vectors are big-endian ([0:N-1], bit 0 = MSB).
- main_clk  in  1  single system clock; rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- reqN_cmd_in  in  4  port N opcode, N=1..4; 0 = idle.
- reqN_tag_in  in  2  port N request tag.
- reqN_data_in  in  32  port N operand bus.
- out_dataN  out  32  port N result.
- out_respN  out  2  port N response code.
- out_tagN  out  2  port N echoed tag.
- scan_in, a_clk, b_clk  in  1  scan hooks; ignored.
- scan_out  out  1  tied 0.

## Operation
- Opcodes:
  - 0001 add: op1+op2.
  - 0010 sub: op1−op2.
  - 0101 shift-left logical: op1 << op2[27:31].
  - 0110 shift-right logical: op1 >> op2[27:31].
  - 0000 idle.
  - Any other opcode is invalid.
- Responses: 00 none, 01 success, 10 overflow/underflow/invalid. Code 11 is never driven.
- Request protocol, per port:
  - Cycle T: cmd≠0. Sample cmd, tag and data (op1).
  - Cycle T+1: sample data as op2. cmd in T+1 is ignored.
  - Earliest next command is cycle T+2. Throughput is one command per 2 cycles per port.
- Arithmetic is unsigned, 32-bit.
  - Add with a carry out of the MSB gives resp 10, data 0.
  - Sub with op2>op1 gives resp 10, data 0.
  - Shifts never overflow. Shift amount 0 returns op1.
- An invalid opcode still consumes its op2 cycle and gives resp 10, data 0, with the tag echoed.
- Ports are fully independent. Simultaneous commands on all four ports produce four simultaneous responses.
- When no response is presented, out_dataN, out_respN and out_tagN are all 0.

## Timing
- Response for a command in cycle T is valid for exactly one cycle, T+3, then returns to 0.
  - End of T: op1 register.
  - End of T+1: op2 register.
  - End of T+2: result register.
- Back-to-back commands at T and T+2 produce responses at T+3 and T+5.
- Per-port state machine:
  - IDLE: cmd≠0 → OPND2. cmd=0 → stay in IDLE.
  - OPND2: unconditionally → IDLE. Loads op2 and launches compute.
- Reset (reset=0), asynchronous:
  - All state machines go to IDLE.
  - All registers clear; every output is 0 immediately.
  - In-flight commands are discarded and produce no response.
- Reset release: the first command is sampled on the first rising edge with reset=1.
- A command whose op2 cycle falls under reset is dropped. Commands sampled after release behave normally.

## Structure
- Package calc_pkg holds:
  - typedefs cmd_t (4 bit), tag_t (2 bit), resp_t (2 bit), data_t (32 bit).
  - constants CMD_IDLE/ADD/SUB/SHL/SHR and RESP_NONE/OK/ERR.
- Sub-module calc_port_unit implements one port: FSM, operand registers, ALU and output register. The top instantiates it four times and ties scan_out to 0.

## Test plan
- Add: port1 cmd=0001, tag=2, op1=0x0000_0005, op2=0x0000_0007 → cycle T+3 out_data1=0x0000_000C, resp=01, tag=2; cycles T+2 and T+4 all zero.
- Overflow/underflow:
  - add 0xFFFF_FFFF+1 → resp=10, data=0.
  - sub 3−5 → resp=10, data=0.
  - sub 5−5 → resp=01, data=0.
- Shifts:
  - shl 0x0000_0001 by 31 → 0x8000_0000, resp 01.
  - shr 0x8000_0000 by 0x0000_0021 (amount 1) → 0x4000_0000.
- Invalid and concurrency:
  - cmd=0011 on port3, tag=1 → resp=10, tag=1, data=0 at T+3.
  - All four ports issue different adds in the same cycle → four correct responses in the same cycle.
- Throughput: port2 issues commands at T and T+2 with tags 0 and 3 → responses at T+3 and T+5 with matching tags. A nonzero cmd driven at T+1 is ignored.
- Reset:
  - Assert reset=0 at T+1 mid-command → outputs 0 immediately and no response at T+3.
  - After release, an add of 1+1 → data=2, resp=01.
